dmem_sram_if: RTL and testbench

- Data-side memory interface for the MEM stage of the 5-stage MIPS pipeline.
- Converts MEM-stage load/store requests into the SRAM-like req/addr_ok/data_ok protocol toward the AXI bridge.
- Produces `stall_from_mem` for the hazard unit and honours pipeline-wide stalls and exception flushes.
- Returns load data to the MEM/WB path.

---
 rtl/dmem_sram_if.sv | 138 +++++++++++++
 tb/tb_dmem_sram_if.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_if.sv
// Purpose: MEM-stage data access bridge; turns load/store requests into a req/addr_ok/data_ok handshake.
// Latency: best-case load holds the pipeline for 2 cycles (IDLE + ADDR); the result is visible in the data_ok cycle.
// Backpressure: holds the request until addr_ok and raises stall_from_mem until data_ok; one transaction in flight.
module dmem_sram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enM,
    input  logic              mem_wrM,
    input  logic [1:0]        mem_sizeM,
    input  logic [ADDR_W-1:0] mem_addrM,
    input  logic [DATA_W-1:0] mem_wdataM,
    input  logic              flush_exceptM,
    input  logic              stall_otherM,
    output logic              stall_from_mem,
    output logic [DATA_W-1:0] mem_rdataM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT             state;
    logic              cancel;
    logic              wrReg;
    logic [1:0]        sizeReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] holdReg;

    logic start;
    logic cancelNow;
    logic dataDone;
    logic loadHit;

    // A flushed instruction never starts; a flush in the current cycle already counts as cancelled.
    assign start     = mem_enM & ~flush_exceptM;
    assign cancelNow = cancel | flush_exceptM;
    assign dataDone  = (state == DATA) & data_data_ok;
    assign loadHit   = dataDone & ~cancelNow & ~wrReg;

    // The request fields come straight from the latched copy so they stay stable while waiting for addr_ok.
    assign data_req   = (state == ADDR);
    assign data_wr    = wrReg;
    assign data_size  = sizeReg;
    assign data_addr  = addrReg;
    assign data_wdata = wdataReg;

    // Completing load bypasses the hold register so the result is usable in the cycle the stall drops.
    assign mem_rdataM = loadHit ? data_rdata : holdReg;

    // Stall decode: depends on state, start, flush and data_ok only, never on stall_otherM.
    always_comb begin
        stall_from_mem = 1'b0;
        case (state)
            IDLE: stall_from_mem = start;
            ADDR: stall_from_mem = ~cancelNow | start;
            DATA: begin
                if (data_data_ok) begin
                    stall_from_mem = cancelNow ? start : 1'b0;
                end else begin
                    stall_from_mem = ~cancelNow | start;
                end
            end
            default: stall_from_mem = 1'b0;
        endcase
    end

    // Transaction sequencing, request latching, cancel tracking and load-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cancel   <= 1'b0;
            wrReg    <= 1'b0;
            sizeReg  <= 2'd0;
            addrReg  <= '0;
            wdataReg <= '0;
            holdReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wrReg    <= mem_wrM;
                        sizeReg  <= mem_sizeM;
                        addrReg  <= mem_addrM;
                        wdataReg <= mem_wdataM;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    // The request is never withdrawn; a flush only marks its result as unwanted.
                    if (flush_exceptM) begin
                        cancel <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        if (cancelNow) begin
                            cancel <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            if (!wrReg) begin
                                holdReg <= data_rdata;
                            end
                            // Park in DONE while another source freezes the pipeline so the access is not reissued.
                            state <= stall_otherM ? DONE : IDLE;
                        end
                    end else if (flush_exceptM) begin
                        cancel <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush_exceptM || !stall_otherM) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_if.sv
// Purpose: self-checking bench for dmem_sram_if with a load-data scoreboard.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
// Backpressure: addr_ok/data_ok are driven per cycle by each scenario task.
module tb_dmem_sram_if;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              mem_enM;
    logic              mem_wrM;
    logic [1:0]        mem_sizeM;
    logic [ADDR_W-1:0] mem_addrM;
    logic [DATA_W-1:0] mem_wdataM;
    logic              flush_exceptM;
    logic              stall_otherM;
    logic              stall_from_mem;
    logic [DATA_W-1:0] mem_rdataM;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    int checks;
    int failures;
    logic [DATA_W-1:0] expQ[$];
    logic [DATA_W-1:0] lastLoad;
    logic [DATA_W-1:0] expVal;

    dmem_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_enM       (mem_enM),
        .mem_wrM       (mem_wrM),
        .mem_sizeM     (mem_sizeM),
        .mem_addrM     (mem_addrM),
        .mem_wdataM    (mem_wdataM),
        .flush_exceptM (flush_exceptM),
        .stall_otherM  (stall_otherM),
        .stall_from_mem(stall_from_mem),
        .mem_rdataM    (mem_rdataM),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, then release the one-shot handshakes.
    task automatic tick();
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        mem_enM    = 1'b1;
        mem_wrM    = wr;
        mem_sizeM  = size;
        mem_addrM  = addr;
        mem_wdataM = wdata;
    endtask

    task automatic slaveData(input logic [31:0] rdata, input logic isLoad);
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        if (isLoad) expQ.push_back(rdata);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (data_req !== 1'b0 || stall_from_mem !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b stall=%b, required req=0 stall=0", data_req, stall_from_mem);
        end
        checks++;
        if (mem_rdataM !== 32'h0 || data_addr !== 32'h0 || data_wdata !== 32'h0 || data_size !== 2'd0 || data_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h size=%0d wr=%b, required all zero",
                     mem_rdataM, data_addr, data_wdata, data_size, data_wr);
        end
    endtask

    task automatic test_load_basic();
        int reqCycles;
        int stallCycles;
        reqCycles = 0;
        stallCycles = 0;
        issue(1'b0, 2'd2, 32'h1000_0004, 32'h0);
        settle();
        reqCycles += int'(data_req);
        stallCycles += int'(stall_from_mem);
        tick();
        data_addr_ok = 1'b1;
        settle();
        reqCycles += int'(data_req);
        stallCycles += int'(stall_from_mem);
        checks++;
        if (data_addr !== 32'h1000_0004 || data_size !== 2'd2 || data_wr !== 1'b0) begin
            failures++;
            $display("FAIL load_req_fields: addr=%h size=%0d wr=%b, required 10000004/2/0", data_addr, data_size, data_wr);
        end
        tick();
        slaveData(32'hDEAD_BEEF, 1'b1);
        settle();
        reqCycles += int'(data_req);
        stallCycles += int'(stall_from_mem);
        expVal = expQ.pop_front();
        lastLoad = expVal;
        checks++;
        if (stall_from_mem !== 1'b0 || mem_rdataM !== expVal) begin
            failures++;
            $display("FAIL load_result: stall=%b rdata=%h, required stall=0 rdata=%h", stall_from_mem, mem_rdataM, expVal);
        end
        checks++;
        if (reqCycles != 1 || stallCycles != 2) begin
            failures++;
            $display("FAIL load_timing: req_cycles=%0d stall_cycles=%0d, required 1 and 2", reqCycles, stallCycles);
        end
        tick();
        mem_enM = 1'b0;
        settle();
        checks++;
        if (mem_rdataM !== lastLoad || stall_from_mem !== 1'b0 || data_req !== 1'b0) begin
            failures++;
            $display("FAIL load_after: rdata=%h stall=%b req=%b, required %h/0/0", mem_rdataM, stall_from_mem, data_req, lastLoad);
        end
    endtask

    task automatic test_store_delayed();
        int bad;
        bad = 0;
        issue(1'b1, 2'd0, 32'h0000_0013, 32'h0000_5A00);
        settle();
        tick();
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            settle();
            if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd0 || data_addr !== 32'h0000_0013 ||
                data_wdata !== 32'h0000_5A00 || stall_from_mem !== 1'b1) bad++;
            if (i != 3) tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL store_addr_phase: bad_cycles=%0d, required 0 (req=%b addr=%h size=%0d wdata=%h)",
                     bad, data_req, data_addr, data_size, data_wdata);
        end
        tick();
        settle();
        checks++;
        if (data_req !== 1'b0 || stall_from_mem !== 1'b1) begin
            failures++;
            $display("FAIL store_wait: req=%b stall=%b, required req=0 stall=1", data_req, stall_from_mem);
        end
        tick();
        slaveData(32'h0, 1'b0);
        settle();
        checks++;
        if (stall_from_mem !== 1'b0) begin
            failures++;
            $display("FAIL store_release: stall=%b, required 0", stall_from_mem);
        end
        tick();
        mem_enM = 1'b0;
        settle();
    endtask

    task automatic test_done_hold();
        int bad;
        bad = 0;
        issue(1'b0, 2'd2, 32'h1000_0100, 32'h0);
        settle();
        tick();
        data_addr_ok = 1'b1;
        tick();
        stall_otherM = 1'b1;
        slaveData(32'h1234_5678, 1'b1);
        settle();
        expVal = expQ.pop_front();
        lastLoad = expVal;
        checks++;
        if (stall_from_mem !== 1'b0 || mem_rdataM !== expVal) begin
            failures++;
            $display("FAIL done_capture: stall=%b rdata=%h, required stall=0 rdata=%h", stall_from_mem, mem_rdataM, expVal);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            data_rdata = 32'hFFFF_0000;
            if (i == 2) stall_otherM = 1'b0;
            settle();
            if (data_req !== 1'b0 || stall_from_mem !== 1'b0 || mem_rdataM !== lastLoad) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL done_hold: bad_cycles=%0d rdata=%h req=%b, required 0 and rdata=%h", bad, mem_rdataM, data_req, lastLoad);
        end
        tick();
        mem_enM = 1'b0;
        settle();
        tick();
        issue(1'b0, 2'd2, 32'h1000_0200, 32'h0);
        settle();
        checks++;
        if (stall_from_mem !== 1'b1 || data_req !== 1'b0) begin
            failures++;
            $display("FAIL done_exit_idle: stall=%b req=%b, required stall=1 req=0", stall_from_mem, data_req);
        end
        tick();
        settle();
        checks++;
        if (data_req !== 1'b1 || data_addr !== 32'h1000_0200) begin
            failures++;
            $display("FAIL done_next_req: req=%b addr=%h, required 1 and 10000200", data_req, data_addr);
        end
        data_addr_ok = 1'b1;
        tick();
        slaveData(32'h0BAD_F00D, 1'b1);
        settle();
        expVal = expQ.pop_front();
        lastLoad = expVal;
        checks++;
        if (mem_rdataM !== expVal || stall_from_mem !== 1'b0) begin
            failures++;
            $display("FAIL next_load: rdata=%h stall=%b, required %h/0", mem_rdataM, stall_from_mem, expVal);
        end
        tick();
        mem_enM = 1'b0;
        settle();
    endtask

    task automatic test_flush_data();
        int bad;
        bad = 0;
        issue(1'b0, 2'd2, 32'h0000_2000, 32'h0);
        settle();
        tick();
        data_addr_ok = 1'b1;
        tick();
        flush_exceptM = 1'b1;
        settle();
        if (stall_from_mem !== 1'b0) bad++;
        tick();
        flush_exceptM = 1'b0;
        mem_enM = 1'b0;
        settle();
        if (stall_from_mem !== 1'b0) bad++;
        tick();
        slaveData(32'hBADB_AD00, 1'b0);
        settle();
        if (stall_from_mem !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL flush_stall: bad_cycles=%0d, required 0", bad);
        end
        checks++;
        if (mem_rdataM !== lastLoad) begin
            failures++;
            $display("FAIL flush_drop: rdata=%h, required %h", mem_rdataM, lastLoad);
        end
        tick();
        settle();
        checks++;
        if (mem_rdataM !== lastLoad || data_req !== 1'b0 || stall_from_mem !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: rdata=%h req=%b stall=%b, required %h/0/0", mem_rdataM, data_req, stall_from_mem, lastLoad);
        end
    endtask

    task automatic test_flush_then_handler();
        int bad;
        bad = 0;
        issue(1'b0, 2'd2, 32'h0000_3000, 32'h0);
        settle();
        tick();
        data_addr_ok = 1'b1;
        tick();
        flush_exceptM = 1'b1;
        settle();
        tick();
        flush_exceptM = 1'b0;
        issue(1'b0, 2'd2, 32'h0000_4000, 32'h0);
        settle();
        if (stall_from_mem !== 1'b1 || data_req !== 1'b0) bad++;
        tick();
        slaveData(32'hAAAA_5555, 1'b0);
        settle();
        if (stall_from_mem !== 1'b1 || mem_rdataM !== lastLoad) bad++;
        tick();
        settle();
        if (stall_from_mem !== 1'b1 || data_req !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL handler_wait: bad_cycles=%0d rdata=%h, required 0 and rdata=%h", bad, mem_rdataM, lastLoad);
        end
        tick();
        settle();
        checks++;
        if (data_req !== 1'b1 || data_addr !== 32'h0000_4000) begin
            failures++;
            $display("FAIL handler_req: req=%b addr=%h, required 1 and 00004000", data_req, data_addr);
        end
        data_addr_ok = 1'b1;
        tick();
        slaveData(32'hCAFE_F00D, 1'b1);
        settle();
        expVal = expQ.pop_front();
        lastLoad = expVal;
        checks++;
        if (mem_rdataM !== expVal || stall_from_mem !== 1'b0) begin
            failures++;
            $display("FAIL handler_data: rdata=%h stall=%b, required %h/0", mem_rdataM, stall_from_mem, expVal);
        end
        tick();
        mem_enM = 1'b0;
        settle();
    endtask

    task automatic test_reset_in_addr();
        issue(1'b0, 2'd2, 32'h0000_5000, 32'h0);
        settle();
        tick();
        settle();
        checks++;
        if (data_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: req=%b, required 1", data_req);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_enM = 1'b0;
        settle();
        checks++;
        if (data_req !== 1'b0 || stall_from_mem !== 1'b0 || mem_rdataM !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: req=%b stall=%b rdata=%h, required 0/0/00000000", data_req, stall_from_mem, mem_rdataM);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        lastLoad = '0;
        rst = 1'b1;
        mem_enM = 1'b0;
        mem_wrM = 1'b0;
        mem_sizeM = 2'd0;
        mem_addrM = '0;
        mem_wdataM = '0;
        flush_exceptM = 1'b0;
        stall_otherM = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;
        test_reset();
        test_load_basic();
        test_store_delayed();
        test_done_hold();
        test_flush_data();
        test_flush_then_handler();
        test_reset_in_addr();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
